// File: rtl/nios2_system_key_debounce_pkg.sv
// rtl/nios2_system_key_debounce_pkg.sv - shared state encoding and defaults for the key debouncer
package nios2_system_key_debounce_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_PEND   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_PEND = 2'd3
  } key_state_e;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;

endpackage

// File: rtl/key_debounce_chan.sv
// rtl/key_debounce_chan.sv - single-bit synchronizer, debounce counter and press/release FSM
module key_debounce_chan
  import nios2_system_key_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = 20,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_key_raw,
  output logic o_key_out,
  output logic o_key_press,
  output logic o_key_release
);

  localparam logic             L_IDLE = (ACTIVE_LOW != 0);
  localparam logic [CNT_W-1:0] L_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] L_ONE  = CNT_W'(1);

  logic             r_sync1;
  logic             r_sync2;
  logic [CNT_W-1:0] r_cnt;
  key_state_e       r_state;
  logic             r_out;
  logic             r_press;
  logic             r_release;
  logic             w_p;

  // w_p is 1 when the key is pressed, regardless of board polarity
  assign w_p = r_sync2 ^ L_IDLE;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sync1 <= L_IDLE;
      r_sync2 <= L_IDLE;
    end else begin
      r_sync1 <= i_key_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Entering a *_PEND state counts that first mismatching sample, so cnt starts at 1
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= RELEASED;
      r_cnt     <= '0;
      r_out     <= L_IDLE;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_press   <= 1'b0;
      r_release <= 1'b0;
      case (r_state)
        RELEASED: begin
          if (w_p) begin
            r_state <= PRESS_PEND;
            r_cnt   <= L_ONE;
          end else begin
            r_cnt   <= '0;
          end
        end
        PRESS_PEND: begin
          if (!w_p) begin
            r_state <= RELEASED;
            r_cnt   <= '0;
          end else if (r_cnt == L_LAST) begin
            r_state <= PRESSED;
            r_cnt   <= '0;
            r_out   <= ~L_IDLE;
            r_press <= 1'b1;
          end else begin
            r_cnt   <= r_cnt + L_ONE;
          end
        end
        PRESSED: begin
          if (!w_p) begin
            r_state <= RELEASE_PEND;
            r_cnt   <= L_ONE;
          end else begin
            r_cnt   <= '0;
          end
        end
        RELEASE_PEND: begin
          if (w_p) begin
            r_state <= PRESSED;
            r_cnt   <= '0;
          end else if (r_cnt == L_LAST) begin
            r_state   <= RELEASED;
            r_cnt     <= '0;
            r_out     <= L_IDLE;
            r_release <= 1'b1;
          end else begin
            r_cnt     <= r_cnt + L_ONE;
          end
        end
        default: begin
          r_state <= RELEASED;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign o_key_out     = r_out;
  assign o_key_press   = r_press;
  assign o_key_release = r_release;

endmodule

// File: rtl/nios2_system_key_debounce.sv
// rtl/nios2_system_key_debounce.sv - multi-channel push-button debouncer feeding the key PIO
module nios2_system_key_debounce
  import nios2_system_key_debounce_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = 20,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_key_raw,
  output logic [WIDTH-1:0] o_key_out,
  output logic [WIDTH-1:0] o_key_press,
  output logic [WIDTH-1:0] o_key_release
);

  for (genvar g = 0; g < WIDTH; g++) begin : g_chan
    key_debounce_chan #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W),
      .ACTIVE_LOW     (ACTIVE_LOW)
    ) u_chan (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_key_raw    (i_key_raw[g]),
      .o_key_out    (o_key_out[g]),
      .o_key_press  (o_key_press[g]),
      .o_key_release(o_key_release[g])
    );
  end

endmodule

// File: tb/tb_nios2_system_key_debounce.sv
// tb/tb_nios2_system_key_debounce.sv - directed self-checking bench for the key debouncer
module tb_nios2_system_key_debounce;

  logic       clk;
  logic       reset;
  logic [3:0] key_raw;
  logic [3:0] key_out;
  logic [3:0] key_press;
  logic [3:0] key_release;

  int n_assert = 0;
  int n_fail   = 0;

  nios2_system_key_debounce #(
    .WIDTH          (4),
    .DEBOUNCE_CYCLES(8),
    .CNT_W          (4),
    .ACTIVE_LOW     (1)
  ) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_key_raw    (key_raw),
    .o_key_out    (key_out),
    .o_key_press  (key_press),
    .o_key_release(key_release)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] e_out,
                         input logic [3:0] e_press, input logic [3:0] e_rel);
    chk({tag, "_out"}, key_out, e_out);
    chk({tag, "_press"}, key_press, e_press);
    chk({tag, "_release"}, key_release, e_rel);
  endtask

  initial begin
    reset   = 1'b1;
    key_raw = 4'hF;
    tick();
    chk_all("in_reset", 4'hF, 4'h0, 4'h0);
    tick();
    reset = 1'b0;

    // idle keys: no strobes after reset release
    for (int n = 1; n <= 20; n++) begin
      tick();
      chk_all("idle", 4'hF, 4'h0, 4'h0);
    end

    // key 0 press: accepted on edge 10
    key_raw = 4'hE;
    for (int n = 1; n <= 14; n++) begin
      tick();
      chk_all("press0", (n >= 10) ? 4'hE : 4'hF, (n == 10) ? 4'h1 : 4'h0, 4'h0);
    end

    key_raw = 4'hF;
    for (int n = 1; n <= 12; n++) begin
      tick();
      chk_all("release0", (n >= 10) ? 4'hF : 4'hE, 4'h0, (n == 10) ? 4'h1 : 4'h0);
    end

    // key 1 bouncing with 3-cycle runs never qualifies
    for (int n = 0; n < 40; n++) begin
      key_raw = (((n / 3) % 2) == 0) ? 4'hD : 4'hF;
      tick();
      chk_all("bounce1", 4'hF, 4'h0, 4'h0);
    end
    key_raw = 4'hF;
    for (int n = 1; n <= 12; n++) begin
      tick();
      chk_all("bounce1_settle", 4'hF, 4'h0, 4'h0);
    end

    // keys 3 and 2 together
    key_raw = 4'h3;
    for (int n = 1; n <= 30; n++) begin
      tick();
      chk_all("press32", (n >= 10) ? 4'h3 : 4'hF, (n == 10) ? 4'hC : 4'h0, 4'h0);
    end
    key_raw = 4'hF;
    for (int n = 1; n <= 30; n++) begin
      tick();
      chk_all("release32", (n >= 10) ? 4'hF : 4'h3, 4'h0, (n == 10) ? 4'hC : 4'h0);
    end

    // reset mid-count with key 0 held, then fresh debounce
    key_raw = 4'hE;
    for (int n = 1; n <= 5; n++) begin
      tick();
      chk_all("pend0", 4'hF, 4'h0, 4'h0);
    end
    reset = 1'b1;
    #1;
    chk_all("async_reset", 4'hF, 4'h0, 4'h0);
    tick();
    reset = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      tick();
      chk_all("post_reset0", (n >= 10) ? 4'hE : 4'hF, (n == 10) ? 4'h1 : 4'h0, 4'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
